// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and constants; this slice holds the retirement-monitor additions.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    MON_RUN    = 2'd0,
    MON_DRAIN  = 2'd1,
    MON_HALTED = 2'd2
  } mon_state_e;

  typedef enum logic [2:0] {
    HALT_NONE   = 3'd0,
    HALT_ECALL  = 3'd1,
    HALT_EBREAK = 3'd2,
    HALT_MAXCYC = 3'd3,
    HALT_WDOG   = 3'd4
  } halt_cause_e;

  // A slot carries real work unless it is the all-zero flush value or a canonical NOP.
  function automatic logic instr_is_real(input logic [XLEN-1:0] instr);
    return (instr != '0) && (instr != INSTR_NOP);
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating statistic counter: adds 0..3 per enabled cycle and sticks at all-ones.
module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  localparam int unsigned SUM_W = W + 1;

  logic [W:0] sum;

  assign sum = {1'b0, cnt} + SUM_W'(inc);

  // Synchronous clear has priority; a carry out means the counter pins at its maximum.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Retirement monitor for the dual-issue core: statistics plus ECALL/EBREAK, cycle-budget
// and (optional) watchdog halt detection with a drain window before halt_req.
// Optional feature macro: PERF_MON_WDOG_EN enables the no-retire watchdog.
module pipe_perf_monitor
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WDOG_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [31:0]      instr_e,
  input  logic [31:0]      instr_e1,
  input  logic             bubble_ex,
  input  logic             stall,
  input  logic             br_taken0,
  input  logic             br_taken1,
  input  logic             fwd_rs1,
  input  logic             fwd_rs2,
  output mon_state_e       state,
  output logic             halt_req,
  output halt_cause_e      halt_cause,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired0,
  output logic [CNT_W-1:0] retired1,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);

  mon_state_e         state_nxt;
  halt_cause_e        cause_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_nxt;

  logic             run;
  logic             vld0;
  logic             vld1;
  logic             sys_hit;
  halt_cause_e      sys_cause;
  logic [CNT_W-1:0] cyc_post;
  logic             max_hit;
  logic             wdog_hit;

  assign run  = (state == MON_RUN);
  assign vld0 = !bubble_ex && instr_is_real(instr_e);
  assign vld1 = instr_is_real(instr_e1);

  // System-instruction decode; slot 0 is older in program order so it wins.
  always_comb begin
    sys_hit   = 1'b0;
    sys_cause = HALT_NONE;
    if (vld0 && (instr_e == INSTR_ECALL)) begin
      sys_hit   = 1'b1;
      sys_cause = HALT_ECALL;
    end else if (vld0 && (instr_e == INSTR_EBREAK)) begin
      sys_hit   = 1'b1;
      sys_cause = HALT_EBREAK;
    end else if (vld1 && (instr_e1 == INSTR_ECALL)) begin
      sys_hit   = 1'b1;
      sys_cause = HALT_ECALL;
    end else if (vld1 && (instr_e1 == INSTR_EBREAK)) begin
      sys_hit   = 1'b1;
      sys_cause = HALT_EBREAK;
    end
  end

  // Budget compares against the cycle count this cycle will leave behind.
  assign cyc_post = (&cycles) ? cycles : cycles + CNT_W'(1);
  assign max_hit  = (max_cycles != '0) && (cyc_post == max_cycles);

`ifdef PERF_MON_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_nxt;

  assign wdog_nxt = (vld0 || vld1) ? '0 : wdog_cnt + WDOG_W'(1);
  assign wdog_hit = (wdog_nxt == WDOG_W'(WDOG_CYCLES));

  // Consecutive no-retire RUN cycles; frozen once the monitor leaves RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (run) begin
      wdog_cnt <= wdog_nxt;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state and cause selection; precedence is system, then budget, then watchdog.
  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    drain_nxt = drain_cnt;
    unique case (state)
      MON_RUN: begin
        if (sys_hit) begin
          cause_nxt = sys_cause;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = MON_HALTED;
          end else begin
            state_nxt = MON_DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end else if (max_hit) begin
          cause_nxt = HALT_MAXCYC;
          state_nxt = MON_HALTED;
        end else if (wdog_hit) begin
          cause_nxt = HALT_WDOG;
          state_nxt = MON_HALTED;
        end
      end
      MON_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = MON_HALTED;
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      MON_HALTED: begin
        state_nxt = MON_HALTED;
      end
      default: begin
        state_nxt = MON_RUN;
      end
    endcase
  end

  // State, cause, drain timer and the level halt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MON_RUN;
      halt_cause <= HALT_NONE;
      drain_cnt  <= '0;
      halt_req   <= 1'b0;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
      drain_cnt  <= drain_nxt;
      halt_req   <= (state_nxt == MON_HALTED);
    end
  end

  // Statistics: all advance only while in RUN, including the halting cycle itself.
  perf_sat_counter #(.W(CNT_W)) u_cycles (
    .clk(clk), .clr(rst), .en(run), .inc(2'd1), .cnt(cycles)
  );
  perf_sat_counter #(.W(CNT_W)) u_retired0 (
    .clk(clk), .clr(rst), .en(run), .inc({1'b0, vld0}), .cnt(retired0)
  );
  perf_sat_counter #(.W(CNT_W)) u_retired1 (
    .clk(clk), .clr(rst), .en(run), .inc({1'b0, vld1}), .cnt(retired1)
  );
  perf_sat_counter #(.W(CNT_W)) u_dual (
    .clk(clk), .clr(rst), .en(run), .inc({1'b0, vld0 && vld1}), .cnt(dual_cnt)
  );
  perf_sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .clr(rst), .en(run), .inc({1'b0, stall}), .cnt(stall_cnt)
  );
  perf_sat_counter #(.W(CNT_W)) u_br (
    .clk(clk), .clr(rst), .en(run), .inc(2'(br_taken0) + 2'(br_taken1)), .cnt(br_cnt)
  );
  perf_sat_counter #(.W(CNT_W)) u_fwd (
    .clk(clk), .clr(rst), .en(run), .inc(2'(fwd_rs1) + 2'(fwd_rs2)), .cnt(fwd_cnt)
  );

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: per-cycle scoreboard against a behavioural model plus
// directed spot checks; also exercises the saturating counter at a narrow width.
module tb_pipe_perf_monitor;
  import rv32i_pkg::*;

  localparam int unsigned CW = 32;
  localparam int unsigned DC = 2;
  localparam int unsigned WD = 16;
  localparam logic [31:0] ADDI = 32'h0010_8093;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] ECAL = 32'h0000_0073;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] max_cycles = '0;
  logic [31:0] instr_e = '0;
  logic [31:0] instr_e1 = '0;
  logic bubble_ex = 1'b0, stall = 1'b0, br_taken0 = 1'b0, br_taken1 = 1'b0;
  logic fwd_rs1 = 1'b0, fwd_rs2 = 1'b0;

  mon_state_e  st, st0;
  halt_cause_e hc, hc0;
  logic        hr, hr0;
  logic [CW-1:0] cyc, r0, r1, dual, stl, br, fwd;
  logic [CW-1:0] z_cyc, z_r0, z_r1, z_dual, z_stl, z_br, z_fwd;

  logic       s_clr = 1'b1, s_en = 1'b0;
  logic [1:0] s_inc = 2'd0;
  logic [2:0] s_cnt;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(CW), .DRAIN_CYCLES(DC), .WDOG_CYCLES(WD)) u_dut (
    .clk(clk), .rst(rst), .max_cycles(max_cycles), .instr_e(instr_e), .instr_e1(instr_e1),
    .bubble_ex(bubble_ex), .stall(stall), .br_taken0(br_taken0), .br_taken1(br_taken1),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .state(st), .halt_req(hr), .halt_cause(hc),
    .cycles(cyc), .retired0(r0), .retired1(r1), .dual_cnt(dual), .stall_cnt(stl),
    .br_cnt(br), .fwd_cnt(fwd)
  );

  pipe_perf_monitor #(.CNT_W(CW), .DRAIN_CYCLES(0), .WDOG_CYCLES(WD)) u_dut0 (
    .clk(clk), .rst(rst), .max_cycles(max_cycles), .instr_e(instr_e), .instr_e1(instr_e1),
    .bubble_ex(bubble_ex), .stall(stall), .br_taken0(br_taken0), .br_taken1(br_taken1),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .state(st0), .halt_req(hr0), .halt_cause(hc0),
    .cycles(z_cyc), .retired0(z_r0), .retired1(z_r1), .dual_cnt(z_dual), .stall_cnt(z_stl),
    .br_cnt(z_br), .fwd_cnt(z_fwd)
  );

  perf_sat_counter #(.W(3)) u_sat (
    .clk(clk), .clr(s_clr), .en(s_en), .inc(s_inc), .cnt(s_cnt)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        hr;
    logic [2:0]  hc;
    logic [31:0] cyc, r0, r1, dual, stl, br, fwd;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  mon_state_e  m_st = MON_RUN;
  halt_cause_e m_hc = HALT_NONE;
  logic [31:0] m_cyc = '0, m_r0 = '0, m_r1 = '0, m_dual = '0, m_stl = '0, m_br = '0, m_fwd = '0;
  int m_drain = 0;
  int m_wd = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_step();
    logic v0, v1, sys;
    halt_cause_e sc;
    if (rst) begin
      m_st = MON_RUN; m_hc = HALT_NONE; m_drain = 0; m_wd = 0;
      m_cyc = '0; m_r0 = '0; m_r1 = '0; m_dual = '0; m_stl = '0; m_br = '0; m_fwd = '0;
    end else if (m_st == MON_RUN) begin
      v0 = !bubble_ex && instr_e != 32'h0 && instr_e != NOPI;
      v1 = instr_e1 != 32'h0 && instr_e1 != NOPI;
      m_cyc  = sat_add(m_cyc, 1);
      m_r0   = sat_add(m_r0, int'(v0));
      m_r1   = sat_add(m_r1, int'(v1));
      m_dual = sat_add(m_dual, int'(v0 && v1));
      m_stl  = sat_add(m_stl, int'(stall));
      m_br   = sat_add(m_br, int'(br_taken0) + int'(br_taken1));
      m_fwd  = sat_add(m_fwd, int'(fwd_rs1) + int'(fwd_rs2));
      m_wd   = (v0 || v1) ? 0 : m_wd + 1;
      sys = 1'b1;
      sc  = HALT_NONE;
      if (v0 && instr_e == ECAL)        sc = HALT_ECALL;
      else if (v0 && instr_e == EBRK)   sc = HALT_EBREAK;
      else if (v1 && instr_e1 == ECAL)  sc = HALT_ECALL;
      else if (v1 && instr_e1 == EBRK)  sc = HALT_EBREAK;
      else sys = 1'b0;
      if (sys) begin
        m_hc = sc;
        m_st = MON_DRAIN;
        m_drain = int'(DC) - 1;
      end else if (max_cycles != 0 && m_cyc == max_cycles) begin
        m_hc = HALT_MAXCYC;
        m_st = MON_HALTED;
      end
`ifdef PERF_MON_WDOG_EN
      else if (m_wd == int'(WD)) begin
        m_hc = HALT_WDOG;
        m_st = MON_HALTED;
      end
`endif
    end else if (m_st == MON_DRAIN) begin
      if (m_drain == 0) m_st = MON_HALTED;
      else m_drain--;
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic [31:0] i0, input logic [31:0] i1,
                      input logic bub, input logic sl, input logic b0, input logic b1,
                      input logic f1, input logic f2);
    exp_t e;
    rst = r; instr_e = i0; instr_e1 = i1; bubble_ex = bub; stall = sl;
    br_taken0 = b0; br_taken1 = b1; fwd_rs1 = f1; fwd_rs2 = f2;
    model_step();
    sb_q.push_back({m_st, (m_st == MON_HALTED), m_hc, m_cyc, m_r0, m_r1, m_dual,
                    m_stl, m_br, m_fwd});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_state", 64'(st), 64'(e.st));
    check("sb_halt_req", 64'(hr), 64'(e.hr));
    check("sb_cause", 64'(hc), 64'(e.hc));
    check("sb_cycles", 64'(cyc), 64'(e.cyc));
    check("sb_retired0", 64'(r0), 64'(e.r0));
    check("sb_retired1", 64'(r1), 64'(e.r1));
    check("sb_dual", 64'(dual), 64'(e.dual));
    check("sb_stall", 64'(stl), 64'(e.stl));
    check("sb_br", 64'(br), 64'(e.br));
    check("sb_fwd", 64'(fwd), 64'(e.fwd));
  endtask

  task automatic do_reset();
    step(1'b1, ADDI, ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ADDI in both slots with varied side-band activity.
  task automatic run_addi(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, ADDI, ADDI, 1'b0, (i % 2) == 0, (i % 3) == 0, (i % 4) == 0,
           (i % 2) == 0, (i % 5) == 0);
    end
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{2, 4, 6, 7, 7};

    // 1: reset values and straight-line dual issue
    max_cycles = '0;
    do_reset();
    check("rst_state", 64'(st), 64'(MON_RUN));
    check("rst_halt_req", 64'(hr), 64'd0);
    check("rst_cause", 64'(hc), 64'(HALT_NONE));
    check("rst_cycles", 64'(cyc), 64'd0);
    run_addi(10);
    check("t1_cycles", 64'(cyc), 64'd10);
    check("t1_retired0", 64'(r0), 64'd10);
    check("t1_retired1", 64'(r1), 64'd10);
    check("t1_dual", 64'(dual), 64'd10);
    check("t1_stall", 64'(stl), 64'd5);
    check("t1_br", 64'(br), 64'd7);
    check("t1_fwd", 64'(fwd), 64'd7);
    check("t1_halt_req", 64'(hr), 64'd0);
    // bubbled ECALL in slot 0 is not a retirement and must not halt
    step(1'b0, ECAL, ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, NOPI, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, ADDI, NOPI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1b_state", 64'(st), 64'(MON_RUN));
    check("t1b_retired0", 64'(r0), 64'd11);
    check("t1b_retired1", 64'(r1), 64'd11);
    check("t1b_dual", 64'(dual), 64'd10);

    // 2: ECALL in slot 1 on cycle 7 (slot 0 bubbled that cycle)
    do_reset();
    run_addi(6);
    step(1'b0, ADDI, ECAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_drain_state", 64'(st), 64'(MON_DRAIN));
    check("t2_drain_hr", 64'(hr), 64'd0);
    check("t2_nodrain_state", 64'(st0), 64'(MON_HALTED));
    check("t2_nodrain_hr", 64'(hr0), 64'd1);
    run_addi(1);
    check("t2_c9_state", 64'(st), 64'(MON_DRAIN));
    run_addi(1);
    check("t2_c10_state", 64'(st), 64'(MON_HALTED));
    check("t2_c10_hr", 64'(hr), 64'd1);
    check("t2_cause", 64'(hc), 64'(HALT_ECALL));
    check("t2_retired1", 64'(r1), 64'd7);
    check("t2_retired0", 64'(r0), 64'd6);
    check("t2_cycles", 64'(cyc), 64'd7);
    step(1'b0, EBRK, EBRK, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, EBRK, EBRK, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t2_held_cause", 64'(hc), 64'(HALT_ECALL));
    check("t2_held_stall", 64'(stl), 64'd3);

    // 3: EBREAK slot 0 + ECALL slot 1 in the cycle the budget is also reached
    do_reset();
    max_cycles = 32'd3;
    run_addi(2);
    step(1'b0, EBRK, ECAL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_state", 64'(st), 64'(MON_DRAIN));
    check("t3_cause", 64'(hc), 64'(HALT_EBREAK));
    check("t3_nodrain_cause", 64'(hc0), 64'(HALT_EBREAK));
    run_addi(2);

    // 4: cycle budget of 20
    do_reset();
    max_cycles = 32'd20;
    run_addi(19);
    check("t4_c19_state", 64'(st), 64'(MON_RUN));
    run_addi(1);
    check("t4_state", 64'(st), 64'(MON_HALTED));
    check("t4_cause", 64'(hc), 64'(HALT_MAXCYC));
    check("t4_cycles", 64'(cyc), 64'd20);
    run_addi(3);
    check("t4_cycles_held", 64'(cyc), 64'd20);

    // 5: no retirements at all
    do_reset();
    max_cycles = '0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, NOPI, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PERF_MON_WDOG_EN
      if (i == 15) check("t5_c15_state", 64'(st), 64'(MON_RUN));
      if (i == 16) begin
        check("t5_wdog_state", 64'(st), 64'(MON_HALTED));
        check("t5_wdog_cause", 64'(hc), 64'(HALT_WDOG));
      end
`endif
    end
`ifndef PERF_MON_WDOG_EN
    check("t5_state", 64'(st), 64'(MON_RUN));
    check("t5_hr", 64'(hr), 64'd0);
    check("t5_cycles", 64'(cyc), 64'd100);
`endif

    // 6: reset while draining and while halted
    do_reset();
    run_addi(3);
    step(1'b0, ECAL, ADDI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_drain", 64'(st), 64'(MON_DRAIN));
    do_reset();
    check("t6_state", 64'(st), 64'(MON_RUN));
    check("t6_cause", 64'(hc), 64'(HALT_NONE));
    check("t6_cycles", 64'(cyc), 64'd0);
    check("t6_retired0", 64'(r0), 64'd0);
    step(1'b0, ADDI, EBRK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_addi(3);
    check("t6_halted", 64'(st), 64'(MON_HALTED));
    do_reset();
    check("t6_rst_halted_state", 64'(st), 64'(MON_RUN));
    check("t6_rst_halted_hr", 64'(hr), 64'd0);

    // Saturating counter at 3 bits
    s_clr = 1'b1; s_en = 1'b0; s_inc = 2'd0;
    @(posedge clk); #1;
    check("sat_clr", 64'(s_cnt), 64'd0);
    s_clr = 1'b0; s_en = 1'b0; s_inc = 2'd2;
    @(posedge clk); #1;
    check("sat_hold", 64'(s_cnt), 64'd0);
    s_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("sat_step", 64'(s_cnt), 64'(sat_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
